// File: rtl/input_debounce_pkg.sv
// Shared constants and types for the two-channel input debouncer.
// Latency: n/a (package only).
// Backpressure: n/a (no handshakes in this block).
//
// Holds the default parameter values used by input_debounce2 and the
// per-channel state struct {q, cnt} exported by each debounce_chan.
package input_debounce_pkg;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int DB_THRESH_DEF   = 8;
  localparam int DB_CNT_W_DEF    = 4;

  // Widest counter the exported state struct can carry. Each channel keeps its
  // own DB_CNT_W-wide counter and zero-extends it into this field.
  localparam int CNT_W_MAX = 16;

  typedef struct packed {
    logic                 q;    // debounced level
    logic [CNT_W_MAX-1:0] cnt;  // consecutive mismatch count
  } chan_state_t;

endpackage : input_debounce_pkg

// File: rtl/debounce_chan.sv
// One debounce channel: synchronizer, mismatch counter, output level, rise pulse.
// Latency: a stable raw change reaches st.q SYNC_STAGES+DB_THRESH edges after first sample.
// Backpressure: none; free-running, consumes the raw input every cycle.
//
// Ports:
//   clk, rst  - rising-edge clock, asynchronous active-high reset
//   raw       - asynchronous raw input
//   st        - channel state {q, cnt}; q is the registered debounced level
//   rise      - one-cycle pulse coincident with q first reading 1
// Macro INPUT_DEBOUNCE2_EDGE_EN: when undefined, rise is tied low and no edge
// flop exists.
module debounce_chan
  import input_debounce_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int DB_THRESH   = DB_THRESH_DEF,
  parameter int DB_CNT_W    = DB_CNT_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        raw,
  output chan_state_t st,
  output logic        rise
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic                   q;
  logic [DB_CNT_W-1:0]    cnt;
  logic                   mismatch;
  logic                   flip;

  assign s        = sync[SYNC_STAGES-1];
  assign mismatch = (s != q);
  // Final mismatching cycle: q takes s and the counter clears together.
  assign flip     = mismatch && (cnt == DB_CNT_W'(DB_THRESH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], raw};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q   <= 1'b0;
      cnt <= '0;
    end else if (!mismatch) begin
      cnt <= '0;
    end else if (flip) begin
      q   <= s;
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign st.q   = q;
  assign st.cnt = CNT_W_MAX'(cnt);

`ifdef INPUT_DEBOUNCE2_EDGE_EN
  logic rise_q;

  // Registered alongside q so the pulse lands in the cycle q first reads 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rise_q <= 1'b0;
    end else begin
      rise_q <= flip && s;
    end
  end

  assign rise = rise_q;
`else
  assign rise = 1'b0;
`endif

endmodule : debounce_chan

// File: rtl/input_debounce2.sv
// Two independent debounced inputs (A, B) with rise pulses and a busy flag.
// Latency: SYNC_STAGES+DB_THRESH edges from first sample of a stable change to *_db.
// Backpressure: none; inputs sampled every cycle, outputs always valid.
//
// Ports:
//   clk, rst      - rising-edge clock, asynchronous active-high reset
//   a, b          - asynchronous raw inputs
//   a_db, b_db    - registered debounced levels
//   a_rise,b_rise - one-cycle pulse on *_db 0->1 (tied 0 without the macro)
//   busy          - either channel currently counting mismatches
// Macro INPUT_DEBOUNCE2_EDGE_EN enables the rise pulses.
module input_debounce2
  import input_debounce_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int DB_THRESH   = DB_THRESH_DEF,
  parameter int DB_CNT_W    = DB_CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  output logic a_db,
  output logic b_db,
  output logic a_rise,
  output logic b_rise,
  output logic busy
);

  // Illegal configurations stop elaboration rather than building a bad counter.
  if (DB_THRESH > 2**DB_CNT_W || DB_THRESH < 2 || SYNC_STAGES < 2 ||
      SYNC_STAGES > 4 || DB_CNT_W > CNT_W_MAX) begin : g_bad_params
    $error("input_debounce2: illegal SYNC_STAGES/DB_THRESH/DB_CNT_W");
  end

  chan_state_t st_a;
  chan_state_t st_b;

  debounce_chan #(
    .SYNC_STAGES (SYNC_STAGES),
    .DB_THRESH   (DB_THRESH),
    .DB_CNT_W    (DB_CNT_W)
  ) chan_a (
    .clk  (clk),
    .rst  (rst),
    .raw  (a),
    .st   (st_a),
    .rise (a_rise)
  );

  debounce_chan #(
    .SYNC_STAGES (SYNC_STAGES),
    .DB_THRESH   (DB_THRESH),
    .DB_CNT_W    (DB_CNT_W)
  ) chan_b (
    .clk  (clk),
    .rst  (rst),
    .raw  (b),
    .st   (st_b),
    .rise (b_rise)
  );

  assign a_db = st_a.q;
  assign b_db = st_b.q;
  assign busy = (st_a.cnt != '0) || (st_b.cnt != '0);

endmodule : input_debounce2

// File: tb/tb_input_debounce2.sv
// Directed self-checking bench for input_debounce2 at default parameters.
// Edge numbering: edge 1 is the first rising edge after an input change;
// outputs are sampled 1 time unit after each rising edge.
module tb_input_debounce2;

  logic clk = 1'b0;
  logic rst;
  logic a;
  logic b;
  logic a_db;
  logic b_db;
  logic a_rise;
  logic b_rise;
  logic busy;

  int checks = 0;
  int errors = 0;

`ifdef INPUT_DEBOUNCE2_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  input_debounce2 dut (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .b      (b),
    .a_db   (a_db),
    .b_db   (b_db),
    .a_rise (a_rise),
    .b_rise (b_rise),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, act, exp);
    end
  endtask

  // Advance one rising edge and land just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a_db"},   a_db,   1'b0);
    check({tag, "_b_db"},   b_db,   1'b0);
    check({tag, "_a_rise"}, a_rise, 1'b0);
    check({tag, "_b_rise"}, b_rise, 1'b0);
    check({tag, "_busy"},   busy,   1'b0);
  endtask

  initial begin
    rst = 1'b1;
    a   = 1'b0;
    b   = 1'b0;
    #2;
    check_all_zero("reset_init");
    step();
    step();
    #2 rst = 1'b0;
    step();
    step();
    check_all_zero("post_release");

    // Clean 0->1 step on A: busy over edges 3..9, a_db from edge 10.
    a = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      step();
      check($sformatf("step_a_db_e%0d", e),   a_db,   e >= 10);
      check($sformatf("step_a_rise_e%0d", e), a_rise, EDGE_EN && (e == 10));
      check($sformatf("step_busy_e%0d", e),   busy,   (e >= 3) && (e <= 9));
      check($sformatf("step_b_db_e%0d", e),   b_db,   1'b0);
    end

    // 1->0 on A: a_db drops at edge 10 with no rise pulse.
    a = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      step();
      check($sformatf("fall_a_db_e%0d", e),   a_db,   e < 10);
      check($sformatf("fall_a_rise_e%0d", e), a_rise, 1'b0);
    end

    // Glitch: A high across 5 edges then low; counter peaks at 5 and clears.
    a = 1'b1;
    for (int e = 1; e <= 14; e++) begin
      step();
      if (e == 5) a = 1'b0;
      check($sformatf("glitch_a_db_e%0d", e),   a_db,   1'b0);
      check($sformatf("glitch_a_rise_e%0d", e), a_rise, 1'b0);
      check($sformatf("glitch_busy_e%0d", e),   busy,   (e >= 3) && (e <= 7));
    end

    // Simultaneous rise on A and B: both flip and pulse on edge 10.
    a = 1'b1;
    b = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      step();
      check($sformatf("sim_a_db_e%0d", e),   a_db,   e >= 10);
      check($sformatf("sim_b_db_e%0d", e),   b_db,   e >= 10);
      check($sformatf("sim_a_rise_e%0d", e), a_rise, EDGE_EN && (e == 10));
      check($sformatf("sim_b_rise_e%0d", e), b_rise, EDGE_EN && (e == 10));
    end

    // Return both low before the reset test.
    a = 1'b0;
    b = 1'b0;
    for (int e = 1; e <= 12; e++) step();
    check("settle_a_db", a_db, 1'b0);
    check("settle_b_db", b_db, 1'b0);
    check("settle_busy", busy, 1'b0);

    // Reset mid-count: A held high, rst pulsed between edges after edge 6.
    a = 1'b1;
    for (int e = 1; e <= 6; e++) step();
    check("midrst_busy_before", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    check_all_zero("midrst_async");
    #1 rst = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      step();
      check($sformatf("midrst_a_db_e%0d", e),   a_db,   e >= 10);
      check($sformatf("midrst_a_rise_e%0d", e), a_rise, EDGE_EN && (e == 10));
      check($sformatf("midrst_busy_e%0d", e),   busy,   (e >= 3) && (e <= 9));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_input_debounce2

// File: doc/input_debounce2.md
INPUT_DEBOUNCE2 -- requirements
Module: input_debounce2

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer flops per channel; legal range 2..4.
REQ-002 SHALL have parameter DB_THRESH, default 8: consecutive mismatching cycles required before an output flips; legal range 2..(2**DB_CNT_W).
REQ-003 SHALL have parameter DB_CNT_W, default 4: debounce counter width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all flops rising-edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port a, input, 1 bit: asynchronous raw input, channel A.
REQ-007 SHALL have port b, input, 1 bit: asynchronous raw input, channel B.
REQ-008 SHALL have port a_db, output, 1 bit: debounced A, registered; feeds the downstream inverter/AND stage.
REQ-009 SHALL have port b_db, output, 1 bit: debounced B, registered.
REQ-010 SHALL have port a_rise, output, 1 bit: one-cycle pulse on an a_db 0->1 transition.
REQ-011 SHALL have port b_rise, output, 1 bit: one-cycle pulse on a b_db 0->1 transition.
REQ-012 SHALL have port busy, output, 1 bit: high while either channel counter is nonzero.

Function
REQ-013 Each channel SHALL pass its raw input through a SYNC_STAGES-deep flop chain; s denotes the last stage.
REQ-014 Each channel SHALL hold state {q, cnt}; when s == q, cnt SHALL clear to 0 next cycle.
REQ-015 When s != q and cnt < DB_THRESH-1, cnt SHALL increment by 1; no wrap is permitted.
REQ-016 When s != q and cnt == DB_THRESH-1, q SHALL load s and cnt SHALL clear in the same cycle.
REQ-017 A stable raw change SHALL appear on *_db exactly SYNC_STAGES+DB_THRESH rising edges after the first edge that samples it.
REQ-018 A raw pulse shorter than DB_THRESH cycles at s SHALL NOT change *_db; cnt SHALL return to 0.
REQ-019 *_rise SHALL be registered and SHALL assert in the same cycle *_db first reads 1, for exactly one cycle; there SHALL be no pulse on 1->0.
REQ-020 Channels SHALL be fully independent; simultaneous A and B transitions SHALL flip both outputs in the same cycle.
REQ-021 busy SHALL be combinational OR of (cnt_a != 0) and (cnt_b != 0).

Reset
REQ-022 On rst high, all sync flops, q, cnt and *_rise SHALL clear to 0 immediately, without waiting for clk.
REQ-023 Reset mid-count SHALL discard the partial count; after release, counting SHALL restart from 0 against q = 0.
REQ-024 Reset-state outputs SHALL be: a_db=0, b_db=0, a_rise=0, b_rise=0, busy=0.

Configuration
REQ-025 Macro INPUT_DEBOUNCE2_EDGE_EN defined: a_rise/b_rise SHALL behave per REQ-019.
REQ-026 Macro INPUT_DEBOUNCE2_EDGE_EN undefined: a_rise/b_rise ports SHALL remain and be tied to 0, and no edge flops SHALL be inferred.

Structure
REQ-027 Package input_debounce_pkg SHALL hold default constants for SYNC_STAGES, DB_THRESH and DB_CNT_W, plus the channel state struct type {q, cnt}.
REQ-028 Sub-module debounce_chan SHALL implement one channel (sync, counter, q, rise) and SHALL be instantiated twice, as instances chan_a and chan_b.
REQ-029 A parameter legality check SHALL fail elaboration when DB_THRESH > 2**DB_CNT_W or SYNC_STAGES < 2.

Verification (defaults: SYNC_STAGES=2, DB_THRESH=8)
REQ-030 Reset: assert rst asynchronously between edges -> all outputs 0 before the next edge; busy=0.
REQ-031 Clean step: a 0->1 held -> a_db=1 on edge 10, a_rise=1 on edge 10 only, busy high edges 3..9.
REQ-032 Glitch: a high for 5 cycles, then low -> a_db stays 0, no a_rise, busy returns to 0.
REQ-033 Simultaneous: a and b rise together -> a_db and b_db flip on the same edge (10); both rise pulses coincide.
REQ-034 Reset mid-count: a held high, rst pulsed at edge 6 -> a_db=0, counting restarts, and a_db=1 10 edges after release.
REQ-035 Macro off: repeat the REQ-031 stimulus without INPUT_DEBOUNCE2_EDGE_EN -> a_db timing unchanged, a_rise constantly 0.
